// File: rtl/regfile_bypass_param.sv
// Parametrised register file: DEPTH x WIDTH storage, one byte-masked write port,
// two combinational read ports with optional write bypass, plus a busy scoreboard.
module regfile_bypass_param #(
  parameter int WIDTH    = 32,
  parameter int DEPTH    = 32,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 regWrite,
  input  logic [ADDR_W-1:0]    writeAddr,
  input  logic [WIDTH-1:0]     writeData,
  input  logic [WIDTH/8-1:0]   byteEn,
  input  logic [ADDR_W-1:0]    readAddr1,
  input  logic [ADDR_W-1:0]    readAddr2,
  output logic [WIDTH-1:0]     readData1,
  output logic [WIDTH-1:0]     readData2,
  input  logic                 busySet,
  input  logic [ADDR_W-1:0]    busyAddr,
  output logic                 busy1,
  output logic                 busy2,
  output logic [DEPTH-1:0]     busyVec
);

  localparam int LANES = WIDTH / 8;

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] busyQ;
  logic [DEPTH-1:0] busyNext;
  logic             writeValid;
  logic             busySetValid;

  function automatic logic addrInRange(input logic [ADDR_W-1:0] a);
    return (32'(a) < 32'(DEPTH));
  endfunction

  function automatic logic isZeroReg(input logic [ADDR_W-1:0] a);
    return (ZERO_REG != 0) && (a == '0);
  endfunction

  function automatic logic [WIDTH-1:0] mergeLanes(
    input logic [WIDTH-1:0] oldVal,
    input logic [WIDTH-1:0] newVal,
    input logic [LANES-1:0] en
  );
    logic [WIDTH-1:0] res;
    res = oldVal;
    for (int i = 0; i < LANES; i++) begin
      if (en[i]) res[8*i +: 8] = newVal[8*i +: 8];
    end
    return res;
  endfunction

  // Gating with reset keeps the bypass path quiet while the array is being cleared.
  assign writeValid   = regWrite && !reset && addrInRange(writeAddr) && !isZeroReg(writeAddr);
  assign busySetValid = busySet && addrInRange(busyAddr) && !isZeroReg(busyAddr);

  // A new producer issued this cycle supersedes the one retiring, so set beats clear.
  always_comb begin
    busyNext = busyQ;
    for (int r = 0; r < DEPTH; r++) begin
      if (busySetValid && (busyAddr == ADDR_W'(r))) begin
        busyNext[r] = 1'b1;
      end else if (writeValid && (writeAddr == ADDR_W'(r))) begin
        busyNext[r] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int r = 0; r < DEPTH; r++) regs[r] <= '0;
      busyQ <= '0;
    end else begin
      for (int r = 0; r < DEPTH; r++) begin
        if (writeValid && (writeAddr == ADDR_W'(r))) begin
          regs[r] <= mergeLanes(regs[r], writeData, byteEn);
        end
      end
      busyQ <= busyNext;
    end
  end

  function automatic logic [WIDTH-1:0] readPort(input logic [ADDR_W-1:0] a);
    logic [WIDTH-1:0] stored;
    stored = '0;
    for (int r = 0; r < DEPTH; r++) begin
      if (a == ADDR_W'(r)) stored = regs[r];
    end
    if (!addrInRange(a) || isZeroReg(a)) begin
      stored = '0;
    end else if ((BYPASS != 0) && writeValid && (writeAddr == a)) begin
      stored = mergeLanes(stored, writeData, byteEn);
    end
    return stored;
  endfunction

  // A forwarded write resolves the hazard in the same cycle, so the flag drops.
  function automatic logic busyPort(input logic [ADDR_W-1:0] a);
    logic b;
    b = 1'b0;
    for (int r = 0; r < DEPTH; r++) begin
      if (a == ADDR_W'(r)) b = busyQ[r];
    end
    if (!addrInRange(a)) begin
      b = 1'b0;
    end else if ((BYPASS != 0) && writeValid && (writeAddr == a)) begin
      b = 1'b0;
    end
    return b;
  endfunction

  always_comb begin
    readData1 = readPort(readAddr1);
    readData2 = readPort(readAddr2);
    busy1     = busyPort(readAddr1);
    busy2     = busyPort(readAddr2);
  end

  assign busyVec = busyQ;

endmodule

// File: tb/tb_regfile_bypass_param.sv
// Directed bench: a default instance (bypass, 32 regs) and a non-bypass
// 24-register instance driven by the same stimulus.
module tb_regfile_bypass_param;

  logic        clk = 1'b0;
  logic        reset;
  logic        regWrite;
  logic [4:0]  writeAddr;
  logic [31:0] writeData;
  logic [3:0]  byteEn;
  logic [4:0]  readAddr1, readAddr2;
  logic        busySet;
  logic [4:0]  busyAddr;

  logic [31:0] rd1A, rd2A, rd1B, rd2B;
  logic        busy1A, busy2A, busy1B, busy2B;
  logic [31:0] busyVecA;
  logic [23:0] busyVecB;

  int tests = 0;
  int failed = 0;

  regfile_bypass_param dut (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
    .writeData(writeData), .byteEn(byteEn), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(rd1A), .readData2(rd2A), .busySet(busySet), .busyAddr(busyAddr),
    .busy1(busy1A), .busy2(busy2A), .busyVec(busyVecA)
  );

  regfile_bypass_param #(.DEPTH(24), .BYPASS(0)) dutNb (
    .clk(clk), .reset(reset), .regWrite(regWrite), .writeAddr(writeAddr),
    .writeData(writeData), .byteEn(byteEn), .readAddr1(readAddr1), .readAddr2(readAddr2),
    .readData1(rd1B), .readData2(rd2B), .busySet(busySet), .busyAddr(busyAddr),
    .busy1(busy1B), .busy2(busy2B), .busyVec(busyVecB)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    regWrite = 1'b0; busySet = 1'b0;
  endtask

  initial begin
    reset = 1'b1; regWrite = 1'b0; writeAddr = '0; writeData = '0; byteEn = '0;
    readAddr1 = '0; readAddr2 = '0; busySet = 1'b0; busyAddr = '0;
    #2;
    for (int a = 0; a < 32; a++) begin
      readAddr1 = 5'(a); readAddr2 = 5'(31 - a);
      #1;
      check("rst_rd1", rd1A, 32'h0);
      check("rst_rd2", rd2A, 32'h0);
    end
    check("rst_busyVecA", busyVecA, 32'h0);
    check("rst_busyVecB", 32'(busyVecB), 32'h0);

    // Write attempted while reset is held
    regWrite = 1'b1; writeAddr = 5'd7; writeData = 32'hA5A5A5A5; byteEn = 4'hF; readAddr1 = 5'd7;
    #1;
    check("rst_nobypass", rd1A, 32'h0);
    check("rst_busy1", 32'(busy1A), 32'h0);
    tick();
    check("rst_edge_ignored", rd1A, 32'h0);
    idle();
    reset = 1'b0;
    tick();
    check("rst_reg7A", rd1A, 32'h0);
    check("rst_reg7B", rd1B, 32'h0);

    // Basic write / read
    regWrite = 1'b1; writeAddr = 5'd5; writeData = 32'hDEADBEEF; byteEn = 4'hF;
    tick();
    idle();
    readAddr1 = 5'd5; readAddr2 = 5'd5;
    #1;
    check("basic_rd1A", rd1A, 32'hDEADBEEF);
    check("basic_rd2A", rd2A, 32'hDEADBEEF);
    check("basic_rd1B", rd1B, 32'hDEADBEEF);

    // Byte lanes
    regWrite = 1'b1; writeAddr = 5'd9; writeData = 32'h11223344; byteEn = 4'hF;
    tick();
    writeData = 32'hAABBCCDD; byteEn = 4'b0101;
    tick();
    idle();
    readAddr1 = 5'd9; readAddr2 = 5'd9;
    #1;
    check("lane_mask", rd1A, 32'h11BB33DD);
    check("lane_maskB", rd2B, 32'h11BB33DD);
    regWrite = 1'b1; writeAddr = 5'd9; writeData = 32'hFFFFFFFF; byteEn = 4'h0;
    tick();
    idle();
    #1;
    check("lane_none", rd1A, 32'h11BB33DD);

    // Zero register
    regWrite = 1'b1; writeAddr = 5'd0; writeData = 32'hFFFFFFFF; byteEn = 4'hF;
    busySet = 1'b1; busyAddr = 5'd0; readAddr1 = 5'd0;
    #1;
    check("zero_bypass", rd1A, 32'h0);
    tick();
    idle();
    #1;
    check("zero_rdA", rd1A, 32'h0);
    check("zero_busyVecA", busyVecA, 32'h0);
    check("zero_busyVecB", 32'(busyVecB), 32'h0);

    // Bypass, with reg3 pending
    busySet = 1'b1; busyAddr = 5'd3;
    tick();
    idle();
    readAddr1 = 5'd3; readAddr2 = 5'd3;
    #1;
    check("byp_pre_busyA", 32'(busy1A), 32'h1);
    check("byp_pre_busyB", 32'(busy1B), 32'h1);
    regWrite = 1'b1; writeAddr = 5'd3; writeData = 32'h12345678; byteEn = 4'hF;
    #1;
    check("byp_rd1A", rd1A, 32'h12345678);
    check("byp_rd2A", rd2A, 32'h12345678);
    check("byp_busy1A", 32'(busy1A), 32'h0);
    check("byp_busy2A", 32'(busy2A), 32'h0);
    check("nobyp_rd1B", rd1B, 32'h0);
    check("nobyp_busy1B", 32'(busy1B), 32'h1);
    tick();
    idle();
    #1;
    check("nobyp_after", rd1B, 32'h12345678);
    check("byp_cleared", busyVecA, 32'h0);

    // Partial bypass on reg9
    regWrite = 1'b1; writeAddr = 5'd9; writeData = 32'h55667788; byteEn = 4'b1010;
    readAddr1 = 5'd9; readAddr2 = 5'd9;
    #1;
    check("pbyp_rd1A", rd1A, 32'h55BB77DD);
    check("pbyp_rd2A", rd2A, 32'h55BB77DD);
    check("pbyp_rd1B", rd1B, 32'h11BB33DD);
    tick();
    idle();
    #1;
    check("pbyp_afterB", rd1B, 32'h55BB77DD);

    // Scoreboard
    busySet = 1'b1; busyAddr = 5'd4; readAddr1 = 5'd4;
    #1;
    check("sb_not_yet", 32'(busy1A), 32'h0);
    tick();
    idle();
    #1;
    check("sb_set", 32'(busy1A), 32'h1);
    check("sb_vec", busyVecA, 32'h00000010);
    regWrite = 1'b1; writeAddr = 5'd4; writeData = 32'h0BADF00D; byteEn = 4'hF;
    tick();
    idle();
    #1;
    check("sb_clear", busyVecA, 32'h0);
    busySet = 1'b1; busyAddr = 5'd4; regWrite = 1'b1; writeAddr = 5'd4;
    tick();
    idle();
    #1;
    check("sb_set_wins", busyVecA, 32'h00000010);
    busySet = 1'b1; busyAddr = 5'd6; regWrite = 1'b1; writeAddr = 5'd4;
    tick();
    idle();
    #1;
    check("sb_both_A", busyVecA, 32'h00000040);
    check("sb_both_B", 32'(busyVecB), 32'h00000040);

    // Out-of-range on the 24-entry instance
    regWrite = 1'b1; writeAddr = 5'd30; writeData = 32'hCAFEF00D; byteEn = 4'hF;
    busySet = 1'b1; busyAddr = 5'd30; readAddr1 = 5'd30;
    #1;
    check("oor_bypA", rd1A, 32'hCAFEF00D);
    check("oor_rdB_pre", rd1B, 32'h0);
    tick();
    idle();
    #1;
    check("oor_rdA", rd1A, 32'hCAFEF00D);
    check("oor_busyA", 32'(busy1A), 32'h1);
    check("oor_rdB", rd1B, 32'h0);
    check("oor_busyB", 32'(busy1B), 32'h0);
    check("oor_vecA", busyVecA, 32'h40000040);
    check("oor_vecB", 32'(busyVecB), 32'h00000040);

    // Asynchronous reset mid-cycle with a write in flight
    regWrite = 1'b1; writeAddr = 5'd5; writeData = 32'h77777777; byteEn = 4'hF;
    readAddr1 = 5'd5; readAddr2 = 5'd30;
    #2;
    reset = 1'b1;
    #1;
    check("arst_rd1A", rd1A, 32'h0);
    check("arst_rd2A", rd2A, 32'h0);
    check("arst_busy2A", 32'(busy2A), 32'h0);
    check("arst_vecA", busyVecA, 32'h0);
    check("arst_vecB", 32'(busyVecB), 32'h0);
    tick();
    idle();
    reset = 1'b0;
    tick();
    check("arst_post_rd1A", rd1A, 32'h0);
    check("arst_post_rd1B", rd1B, 32'h0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/regfile_bypass_param.md
Name: regfile_bypass_param

Overview:
- Parametrised general-purpose register file that succeeds the fixed 32-bit single register: DEPTH registers of WIDTH bits.
- Provides 1 byte-masked write port, 2 combinational read ports, optional write-to-read bypass and an optional hardwired-zero register 0.
- Includes a per-register busy scoreboard that the decode stage uses to detect pending writes.
- Sits between decode (read/issue) and writeback (write) in the pipelined datapath.

Parameters:
- WIDTH, 32: register width in bits; must be a multiple of 8.
- DEPTH, 32: number of registers; 2..256.
- ADDR_W, 5: address width; must satisfy 2^ADDR_W >= DEPTH.
- ZERO_REG, 1: 1 = register 0 always reads 0, ignores writes and is never busy.
- BYPASS, 1: 1 = a same-cycle write is forwarded to the read ports.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  asynchronous, active-high; clears all state immediately.
- regWrite  in  1  write strobe (writeback stage).
- writeAddr  in  ADDR_W  write register index.
- writeData  in  WIDTH  write data.
- byteEn  in  WIDTH/8  byte-lane write mask; bit i covers bits [8i+7:8i].
- readAddr1  in  ADDR_W  read port 1 index.
- readAddr2  in  ADDR_W  read port 2 index.
- readData1  out  WIDTH  read port 1 data.
- readData2  out  WIDTH  read port 2 data.
- busySet  in  1  issue strobe: mark busyAddr as pending a write.
- busyAddr  in  ADDR_W  register to mark busy.
- busy1  out  1  pending-write flag for readAddr1.
- busy2  out  1  pending-write flag for readAddr2.
- busyVec  out  DEPTH  raw scoreboard bits.

Behaviour:
- Reset: while reset=1, all registers and all busy bits = 0, asynchronously. readData1/2 = 0, busy1/2 = 0, busyVec = 0. Edges are ignored while reset is high. Deassertion takes effect at the next rising edge.
- Write: at a rising edge with regWrite=1 and writeAddr < DEPTH, each lane i with byteEn[i]=1 takes writeData's lane; other lanes hold.
  - byteEn = 0: no data change, but the busy clear still applies.
  - writeAddr >= DEPTH: ignored entirely.
  - ZERO_REG=1 and writeAddr=0: ignored.
- Read: purely combinational, 0-cycle latency.
  - readAddr >= DEPTH reads 0.
  - ZERO_REG=1 and readAddr=0 reads 0.
- Bypass (BYPASS=1): if regWrite=1, writeAddr==readAddrN, and the write is valid per the write rules, readDataN = stored value with the byteEn lanes replaced by writeData. BYPASS=0: readDataN shows the stored value until after the edge.
- Both read ports may address the same register, including during a bypassed write; both must then return identical data.
- Scoreboard, per register r, evaluated at each rising edge:
  - set if busySet=1 and busyAddr==r;
  - else clear if regWrite=1 and writeAddr==r;
  - else hold.
- Simultaneous set and clear on the same register: set wins, because the newly issued producer supersedes the retiring one.
- Set and clear on different registers both take effect in the same cycle.
- busySet with busyAddr >= DEPTH, or with busyAddr=0 when ZERO_REG=1: ignored.
- busyN = busyVec[readAddrN]. With BYPASS=1, busyN is forced to 0 when a valid write to readAddrN is present in the same cycle. busyN = 0 for out-of-range addresses.
- Reset asserted mid-operation: an in-flight write is discarded and all busy bits clear. No partial lane writes persist.
- No internal FSM beyond the storage array and the scoreboard. Both update only on the clock edge or on reset.

Test Plan:
- Reset then read: assert reset, then read all addresses 0..31 -> every readData=0 and busyVec=0. Assert reset mid-write (regWrite=1, addr 7) -> reg7 stays 0.
- Basic write/read: write 0xDEADBEEF to reg5 with byteEn=4'hF, then next cycle readAddr1=5, readAddr2=5 -> both readData = 0xDEADBEEF.
- Byte lanes: reg9 = 0x11223344, then write 0xAABBCCDD with byteEn=4'b0101 -> reg9 reads 0x11BB33DD. A write with byteEn=0 leaves 0x11BB33DD unchanged.
- Zero register: write 0xFFFFFFFF to reg0, set busy on reg0 -> readData=0 and busyVec[0]=0.
- Bypass: with reg3=0, drive regWrite=1, addr 3, data 0x12345678, byteEn=4'hF, readAddr1=3 in the same cycle -> readData1=0x12345678 before the edge and busy1=0. With BYPASS=0 -> readData1=0 until after the edge.
- Scoreboard:
  - busySet on reg4 -> busy1=1 for readAddr1=4 from the next cycle;
  - writeback to reg4 -> bit clears;
  - busySet and regWrite both on reg4 in the same cycle -> busyVec[4] stays 1;
  - set on reg6 and write to reg4 together -> busyVec[6]=1 and busyVec[4]=0.
